// File: rtl/comp_pkg.sv
// rtl/comp_pkg.sv - channel indices shared by input_conditioner and comp_core
//   Purpose: names the physical input channels so consumers index by role.
//   Ports:   none (package).
package comp_pkg;

  localparam int N_INPUTS = 4;

  localparam int CH_FORK  = 0;
  localparam int CH_CRANK = 1;
  localparam int CH_TRIP  = 2;
  localparam int CH_MODE  = 3;

endpackage : comp_pkg

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - single-bit debounce, edge and long-press detector
//   Purpose: filters one active-high raw line into a clean level plus
//            registered press / release / long-press pulses.
//   Ports:   Clock, Reset (sync, active-high), raw (active-high, synchronised)
//            level          debounced state
//            pressPulse     1-cycle pulse when level goes 0->1
//            releasePulse   1-cycle pulse when level goes 1->0
//            longPressPulse 1-cycle pulse once per press held LONG_CYCLES
module debounce_channel #(
  parameter int DB_CYCLES   = 160,
  parameter int LONG_CYCLES = 32768
) (
  input  logic Clock,
  input  logic Reset,
  input  logic raw,
  output logic level,
  output logic pressPulse,
  output logic releasePulse,
  output logic longPressPulse
);

  localparam int DbW   = $clog2(DB_CYCLES + 1);
  localparam int HoldW = $clog2(LONG_CYCLES + 1);

  localparam logic [DbW-1:0]   DbLast   = DbW'(DB_CYCLES - 1);
  localparam logic [HoldW-1:0] HoldMax  = HoldW'(LONG_CYCLES);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(LONG_CYCLES - 1);

  logic [DbW-1:0]   dbCnt;
  logic [HoldW-1:0] holdCnt;
  logic             accept;

  // The DB_CYCLES-th consecutive differing sample flips the level.
  always_comb begin
    accept = 1'b0;
    if ((raw != level) && (dbCnt == DbLast)) begin
      accept = 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      level          <= 1'b0;
      dbCnt          <= '0;
      holdCnt        <= '0;
      pressPulse     <= 1'b0;
      releasePulse   <= 1'b0;
      longPressPulse <= 1'b0;
    end else begin
      pressPulse   <= accept & raw;
      releasePulse <= accept & ~raw;

      if (accept) begin
        level <= raw;
        dbCnt <= '0;
      end else if (raw == level) begin
        dbCnt <= '0;
      end else begin
        dbCnt <= dbCnt + 1'b1;
      end

      // Hold counter saturates so the long-press fires once per press.
      // A release accepted on the same edge means the button is already
      // up, so the long-press is dropped in favour of the release.
      if (!level) begin
        holdCnt        <= '0;
        longPressPulse <= 1'b0;
      end else if (holdCnt != HoldMax) begin
        holdCnt        <= holdCnt + 1'b1;
        longPressPulse <= (holdCnt == HoldLast) && !accept;
      end else begin
        longPressPulse <= 1'b0;
      end
    end
  end

endmodule : debounce_channel

// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - debounce/edge-detect stage ahead of comp_core
//   Purpose: inverts the active-low synchronised inputs and runs one
//            independent debounce_channel per input.
//   Ports:   Clock, Reset (sync, active-high)
//            nIn        synchronised raw inputs, active-low
//            Level      debounced state, active-high
//            Press      1-cycle pulse on accepted press
//            Release    1-cycle pulse on accepted release
//            LongPress  1-cycle pulse once per press held LONG_CYCLES
module input_conditioner
  import comp_pkg::*;
#(
  parameter int N_CH        = N_INPUTS,
  parameter int DB_CYCLES   = 160,
  parameter int LONG_CYCLES = 32768
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic [N_CH-1:0] nIn,
  output logic [N_CH-1:0] Level,
  output logic [N_CH-1:0] Press,
  output logic [N_CH-1:0] Release,
  output logic [N_CH-1:0] LongPress
);

  if (DB_CYCLES < 1) begin : gBadDbCycles
    $error("input_conditioner: DB_CYCLES must be >= 1");
  end
  if (LONG_CYCLES < 1) begin : gBadLongCycles
    $error("input_conditioner: LONG_CYCLES must be >= 1");
  end

  for (genvar i = 0; i < N_CH; i++) begin : gCh
    debounce_channel #(
      .DB_CYCLES   (DB_CYCLES),
      .LONG_CYCLES (LONG_CYCLES)
    ) uChannel (
      .Clock          (Clock),
      .Reset          (Reset),
      .raw            (~nIn[i]),
      .level          (Level[i]),
      .pressPulse     (Press[i]),
      .releasePulse   (Release[i]),
      .longPressPulse (LongPress[i])
    );
  end

endmodule : input_conditioner

// File: tb/tb_input_conditioner.sv
// tb/tb_input_conditioner.sv - scoreboard bench for input_conditioner
module tb_input_conditioner;
  import comp_pkg::*;

  localparam int DB   = 4;
  localparam int LONG = 20;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic [3:0] nIn   = 4'hF;
  logic [3:0] Level, Press, Release, LongPress;

  input_conditioner #(
    .N_CH        (4),
    .DB_CYCLES   (DB),
    .LONG_CYCLES (LONG)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .nIn       (nIn),
    .Level     (Level),
    .Press     (Press),
    .Release   (Release),
    .LongPress (LongPress)
  );

  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] p;
    logic [3:0] r;
    logic [3:0] l;
  } ev_t;

  ev_t sb[$];
  int  nVec = 0;
  int  nErr = 0;

  function automatic void chk(string name, int act, int exp);
    nVec++;
    if (act != exp) begin
      nErr++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endfunction

  function automatic void pushEv(int c, logic [3:0] p, logic [3:0] r, logic [3:0] l);
    ev_t e;
    e.cyc = c;
    e.p   = p;
    e.r   = r;
    e.l   = l;
    sb.push_back(e);
  endfunction

  task automatic tick(int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  // Monitor: every pulse the DUT shows is matched against the next expected event.
  always @(negedge Clock) begin : monitor
    ev_t e;
    if (!Reset && ((Press | Release | LongPress) != 4'h0)) begin
      if (sb.size() == 0) begin
        chk("unexpected pulse {P,R,L}", int'({Press, Release, LongPress}), 0);
      end else begin
        e = sb.pop_front();
        chk("pulse cycle", cyc, e.cyc);
        chk("Press", int'(Press), int'(e.p));
        chk("Release", int'(Release), int'(e.r));
        chk("LongPress", int'(LongPress), int'(e.l));
      end
    end
  end

  initial begin
    int t;

    // 1. reset, then idle with all inputs released
    Reset = 1'b1;
    nIn   = 4'hF;
    tick(3);
    chk("outputs in reset", int'({Level, Press, Release, LongPress}), 0);
    Reset = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge Clock);
      chk("idle outputs", int'({Level, Press, Release, LongPress}), 0);
    end
    tick(1);

    // 2. fork press: level flips on the DB-th edge, not before
    t = cyc;
    nIn[CH_FORK] = 1'b0;
    pushEv(t + DB, 4'b0001, 4'b0000, 4'b0000);
    tick(DB - 1);
    chk("fork level before DB edges", int'(Level[CH_FORK]), 0);
    tick(1);
    chk("fork level after DB edges", int'(Level[CH_FORK]), 1);
    tick(4);
    t = cyc;
    nIn[CH_FORK] = 1'b1;
    pushEv(t + DB, 4'b0000, 4'b0001, 4'b0000);
    tick(DB);
    chk("fork level released", int'(Level[CH_FORK]), 0);

    // 3. crank glitches shorter than DB are discarded
    nIn[CH_CRANK] = 1'b0;
    tick(3);
    nIn[CH_CRANK] = 1'b1;
    tick(2);
    for (int i = 0; i < 10; i++) begin
      nIn[CH_CRANK] = 1'b0;
      tick(3);
      nIn[CH_CRANK] = 1'b1;
      tick(1);
    end
    tick(DB);
    chk("crank level after chatter", int'(Level[CH_CRANK]), 0);

    // 4. mode held 40 cycles: press, one long-press, release
    t = cyc;
    nIn[CH_MODE] = 1'b0;
    pushEv(t + DB, 4'b1000, 4'b0000, 4'b0000);
    pushEv(t + DB + LONG, 4'b0000, 4'b0000, 4'b1000);
    tick(30);
    chk("mode level held", int'(Level[CH_MODE]), 1);
    tick(10);
    t = cyc;
    nIn[CH_MODE] = 1'b1;
    pushEv(t + DB, 4'b0000, 4'b1000, 4'b0000);
    tick(DB);
    chk("mode level released", int'(Level[CH_MODE]), 0);
    tick(30);

    // 5. fork and trip fall on the same edge
    t = cyc;
    nIn = 4'b1010;
    pushEv(t + DB, 4'b0101, 4'b0000, 4'b0000);
    tick(DB);
    chk("fork+trip levels", int'(Level), 5);
    tick(2);
    t = cyc;
    nIn = 4'hF;
    pushEv(t + DB, 4'b0000, 4'b0101, 4'b0000);
    tick(DB + 2);

    // 6. reset mid-press, input still low afterwards re-qualifies
    t = cyc;
    nIn[CH_CRANK] = 1'b0;
    pushEv(t + DB, 4'b0010, 4'b0000, 4'b0000);
    tick(DB + 2);
    Reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("outputs during reset", int'({Level, Press, Release, LongPress}), 0);
    end
    Reset = 1'b0;
    t = cyc;
    pushEv(t + DB, 4'b0010, 4'b0000, 4'b0000);
    tick(DB - 1);
    chk("crank level before requalify", int'(Level[CH_CRANK]), 0);
    tick(1);
    chk("crank level requalified", int'(Level[CH_CRANK]), 1);
    tick(2);
    t = cyc;
    nIn[CH_CRANK] = 1'b1;
    pushEv(t + DB, 4'b0000, 4'b0010, 4'b0000);
    tick(DB + 5);

    chk("scoreboard drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule : tb_input_conditioner
